// File: rtl/f3m_cube_root.sv
// Cube root in GF(3^97), p(x) = x^97 + x^12 + 2, computed as A^(3^96) via 48 ninth powers.
// Latency 48 cycles after start; start is ignored while busy (no queueing, no backpressure).
`ifndef M
`define M 97
`endif
`ifndef WIDTH
`define WIDTH 193
`endif

module f3m_cube_root #(
  parameter int NINES = (`M - 1) / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [`WIDTH:0]   A,
  output logic [`WIDTH:0]   C,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [`WIDTH:0] w;
  logic [5:0]      cnt;
  logic [`WIDTH:0] w3;
  logic [`WIDTH:0] w9;

  function automatic logic [1:0] tadd(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Negation in GF(3) swaps the codes for 1 and 2.
  function automatic logic [1:0] tneg(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  // Frobenius spreads trit i to degree 3i; the top degrees fold back using x^97 = 2x^12 + 1.
  function automatic logic [`WIDTH:0] cube(input logic [`WIDTH:0] a);
    logic [577:0] t;
    t = '0;
    for (int i = 0; i < `M; i++)
      t[6*i +: 2] = a[2*i +: 2];
    for (int k = 288; k >= `M; k--) begin
      t[2*(k-85) +: 2] = tadd(t[2*(k-85) +: 2], tneg(t[2*k +: 2]));
      t[2*(k-97) +: 2] = tadd(t[2*(k-97) +: 2], t[2*k +: 2]);
    end
    return t[`WIDTH:0];
  endfunction

  always_comb begin
    w3 = cube(w);
    w9 = cube(w3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      w     <= '0;
      cnt   <= '0;
      C     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w     <= A;
            cnt   <= 6'(NINES);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          w   <= w9;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            C     <= w9;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f3m_cube_root.sv
// Directed and random checks of the GF(3^97) cube-root unit, including handshake timing and reset abort.
module tb_f3m_cube_root;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [193:0] A;
  logic [193:0] C;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  f3m_cube_root dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .C     (C),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [193:0] a;
    logic [193:0] c;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [193:0] act, input logic [193:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference cubing: spread to degree 3i, then reduce with x^97 = 2x^12 + 1.
  function automatic logic [193:0] ref_cube(input logic [193:0] a);
    int c[289];
    logic [193:0] r;
    foreach (c[i]) c[i] = 0;
    for (int i = 0; i < 97; i++) c[3*i] = int'(a[2*i +: 2]);
    for (int k = 288; k >= 97; k--) begin
      c[k-97] = (c[k-97] + c[k]) % 3;
      c[k-85] = (c[k-85] + 2 * c[k]) % 3;
      c[k] = 0;
    end
    r = '0;
    for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'(c[i]);
    return r;
  endfunction

  // Called just after an edge; returns the edge offset (from acceptance) at which done rose.
  task automatic do_op(input logic [193:0] a, output logic [193:0] c,
                       output int done_at, output int busy_cnt);
    A = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = '0;
    busy_cnt = busy ? 1 : 0;
    done_at = -1;
    c = '0;
    for (int n = 1; n <= 60 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_at = n;
        c = C;
      end
    end
  endtask

  logic [193:0] res, ra, x1, x2, x3, x6;
  int dat, bc, d1, d2;
  logic [193:0] c1, c2;

  initial begin
    x1 = '0; x1[3:2]   = 2'b01;
    x2 = '0; x2[5:4]   = 2'b01;
    x3 = '0; x3[7:6]   = 2'b01;
    x6 = '0; x6[13:12] = 2'b01;

    vecs[0].name = "zero";     vecs[0].a = '0;         vecs[0].c = '0;
    vecs[1].name = "one";      vecs[1].a = 194'h1;     vecs[1].c = 194'h1;
    vecs[2].name = "two";      vecs[2].a = 194'h2;     vecs[2].c = 194'h2;
    vecs[3].name = "x3";       vecs[3].a = x3;         vecs[3].c = x1;
    vecs[4].name = "x6";       vecs[4].a = x6;         vecs[4].c = x2;
    vecs[5].name = "2x3";      vecs[5].a = '0;         vecs[5].c = '0;
    vecs[5].a[7:6] = 2'b10;    vecs[5].c[3:2] = 2'b10;
    vecs[6].name = "x3p1";     vecs[6].a = x3 | 194'h1; vecs[6].c = x1 | 194'h1;
    // x^99 reduces to 2x^14 + x^2, so its cube root x^33 exercises the fold-back.
    vecs[7].name = "x33";      vecs[7].a = '0;         vecs[7].c = '0;
    vecs[7].a[29:28] = 2'b10;  vecs[7].a[5:4] = 2'b01; vecs[7].c[67:66] = 2'b01;

    reset = 1'b0;
    start = 1'b0;
    A = '0;
    #3;
    chk("rst_c", C, '0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, res, dat, bc);
      chk({vecs[i].name, "_c"}, res, vecs[i].c);
      chki({vecs[i].name, "_done_at"}, dat, 48);
      chki({vecs[i].name, "_busy_cycles"}, bc, 48);
      @(posedge clk); #1;
      chki({vecs[i].name, "_done_pulse"}, int'(done), 0);
      chki({vecs[i].name, "_busy_after"}, int'(busy), 0);
      chk({vecs[i].name, "_c_hold"}, C, vecs[i].c);
    end

    for (int r = 0; r < 200; r++) begin
      ra = '0;
      for (int t = 0; t < 97; t++) ra[2*t +: 2] = 2'($urandom_range(0, 2));
      do_op(ra, res, dat, bc);
      chk("rand_cube", ref_cube(res), ra);
      chki("rand_busy_cycles", bc, 48);
    end

    // start held high: second operand taken at the first IDLE edge; a mid-run A change is ignored.
    A = x3;
    start = 1'b1;
    @(posedge clk); #1;
    A = x6;
    d1 = -1; d2 = -1; c1 = '0; c2 = '0;
    for (int n = 1; n <= 120 && d2 < 0; n++) begin
      @(posedge clk); #1;
      if (n == 10) A = 194'h1;
      if (n == 11) A = x6;
      if (n == 49) begin
        chki("held_busy_e49", int'(busy), 1);
        chki("held_done_e49", int'(done), 0);
        start = 1'b0;
      end
      if (done) begin
        if (d1 < 0) begin d1 = n; c1 = C; end
        else begin d2 = n; c2 = C; end
      end
    end
    chki("held_done1_at", d1, 48);
    chki("held_done2_at", d2, 97);
    chk("held_c1", c1, x1);
    chk("held_c2", c2, x2);

    // Reset abort mid-run.
    @(posedge clk); #1;
    A = x6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("pre_abort_c", C, x2);
    reset = 1'b0;
    #1;
    chki("abort_busy", int'(busy), 0);
    chki("abort_done", int'(done), 0);
    chk("abort_c", C, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    do_op(x3, res, dat, bc);
    chk("post_abort_c", res, x1);
    chki("post_abort_done_at", dat, 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
